// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding and baud/oversample constants.
package uart_pkg;
  localparam int UART_MIN_BAUD   = 15;
  localparam int UART_BAUD_W     = 20;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-clk tick every baud+1 clocks, restartable from zero via i_clr.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_W = UART_BAUD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic [BAUD_W-1:0] i_baud,
  output logic              o_tick
);
  logic [BAUD_W-1:0] r_div_cnt;
  logic              w_wrap;

  assign w_wrap = (r_div_cnt == i_baud);
  assign o_tick = w_wrap;

  always_ff @(posedge clk) begin
    if (rst || i_clr || w_wrap) r_div_cnt <= '0;
    else                        r_div_cnt <= r_div_cnt + 1'b1;
  end
endmodule

// File: rtl/uart_rx_seq.sv
// UART receive sequencer: rxd sync, start qualify, mid-bit sampling, valid/ack handshake.
// Define UART_RX_PARITY_EN to add an even-parity bit and the o_parity_err port.
module uart_rx_seq
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_sel,
  input  logic                   i_rx_en,
  input  logic [UART_BAUD_W-1:0] i_baud,
  input  logic                   i_rxd,
  input  logic                   i_rd_ack,
  output logic [DATA_BITS-1:0]   o_rx_data,
  output logic                   o_rx_valid,
  output logic                   o_frame_err,
  output logic                   o_overrun,
  output logic                   o_baud_err,
  output logic                   o_busy,
  output logic [3:0]             o_bit_cnt
`ifdef UART_RX_PARITY_EN
  ,
  output logic                   o_parity_err
`endif
);
  localparam int              SAMP_W    = $clog2(OVERSAMPLE);
  localparam logic [SAMP_W-1:0] SAMP_HALF = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [3:0]      BITS_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      BITS_STOP = 4'(DATA_BITS + 1);

  rx_state_t            r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                 r_rxd_d;
  logic [SAMP_W-1:0]    r_samp_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 w_run, w_rxd_s, w_fall, w_tick, w_clr;
  logic                 w_samp_half, w_samp_bit, w_done;

  assign w_run       = i_sel & i_rx_en & (i_baud >= UART_BAUD_W'(UART_MIN_BAUD));
  assign w_rxd_s     = r_sync[SYNC_STAGES-1];
  assign w_fall      = ~w_rxd_s & r_rxd_d;
  assign w_clr       = ~w_run | ((r_state == ST_IDLE) & w_fall);
  assign w_samp_half = w_tick & (r_samp_cnt == SAMP_HALF);
  assign w_samp_bit  = w_tick & (r_samp_cnt == SAMP_LAST);
  assign w_done      = w_run & (r_state == ST_STOP) & w_samp_bit;

  uart_baud_tick #(.BAUD_W(UART_BAUD_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_baud (i_baud),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '1;
      r_rxd_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_rxd};
      r_rxd_d <= w_rxd_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!w_run) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_fall) w_state_nxt = ST_START;
        ST_START: if (w_samp_half) w_state_nxt = w_rxd_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
        ST_DATA:   if (w_samp_bit && r_bit_cnt == BITS_LAST) w_state_nxt = ST_PARITY;
        ST_PARITY: if (w_samp_bit) w_state_nxt = ST_STOP;
`else
        ST_DATA:   if (w_samp_bit && r_bit_cnt == BITS_LAST) w_state_nxt = ST_STOP;
`endif
        ST_STOP:  if (w_samp_bit) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy = (r_state != ST_IDLE);
  end

  // Frame datapath: sample counter, bit counter, shift register
`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  always_ff @(posedge clk) begin
    if (rst)                                   r_par_bit <= 1'b0;
    else if (r_state == ST_PARITY && w_samp_bit) r_par_bit <= w_rxd_s;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst || !w_run) begin
      r_samp_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
    end else begin
      case (r_state)
        ST_START: if (w_tick) r_samp_cnt <= w_samp_half ? '0 : r_samp_cnt + 1'b1;
        ST_DATA: begin
          if (w_samp_bit) begin
            r_samp_cnt <= '0;
            r_shreg    <= {w_rxd_s, r_shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
            r_bit_cnt  <= r_bit_cnt + 1'b1;
`else
            r_bit_cnt  <= (r_bit_cnt == BITS_LAST) ? BITS_STOP : r_bit_cnt + 1'b1;
`endif
          end else if (w_tick) begin
            r_samp_cnt <= r_samp_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (w_samp_bit) begin
            r_samp_cnt <= '0;
            r_bit_cnt  <= BITS_STOP;
          end else if (w_tick) begin
            r_samp_cnt <= r_samp_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_samp_bit) begin
            r_samp_cnt <= '0;
            r_bit_cnt  <= '0;
          end else if (w_tick) begin
            r_samp_cnt <= r_samp_cnt + 1'b1;
          end
        end
        default: begin
          r_samp_cnt <= '0;
          r_bit_cnt  <= '0;
        end
      endcase
    end
  end

  assign o_bit_cnt = r_bit_cnt;

  // Register-file handshake and status flags survive a disable; only rst clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rx_data   <= '0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      o_baud_err  <= 1'b0;
    end else begin
      o_baud_err <= i_sel & i_rx_en & (i_baud < UART_BAUD_W'(UART_MIN_BAUD));
      if (w_done) begin
        o_rx_data   <= r_shreg;
        o_frame_err <= ~w_rxd_s;
        o_rx_valid  <= 1'b1;
      end else if (i_rd_ack) begin
        o_rx_valid  <= 1'b0;
      end
      if (w_done && o_rx_valid && !i_rd_ack) o_overrun <= 1'b1;
      else if (i_rd_ack && o_rx_valid)       o_overrun <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)         o_parity_err <= 1'b0;
    else if (w_done) o_parity_err <= (^r_shreg) ^ r_par_bit;
  end
`endif
endmodule

// File: tb/tb_uart_rx_seq.sv
// Bench for uart_rx_seq: frame table, corner-case sequences and randomized frames vs a word-level model.
`timescale 1ns/1ps
module tb_uart_rx_seq;
  logic        clk = 1'b0;
  logic        rst, sel, rx_en, rxd, rd_ack;
  logic [19:0] baud;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, overrun, baud_err, busy;
  logic [3:0]  bit_cnt;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, t_fall = 0, t_rise = 0;
  logic prev_v = 1'b0;
  int bitclk;

  // word-level reference state
  logic [7:0] m_data;
  logic       m_valid, m_ferr, m_ovr;

  typedef struct {
    logic [7:0] d;
    logic       stopb;
    bit         ack;
    logic [7:0] e_data;
    logic       e_valid, e_ferr, e_ovr;
  } vec_t;
  vec_t tbl[5];

  uart_rx_seq #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_sel      (sel),
    .i_rx_en    (rx_en),
    .i_baud     (baud),
    .i_rxd      (rxd),
    .i_rd_ack   (rd_ack),
    .o_rx_data  (rx_data),
    .o_rx_valid (rx_valid),
    .o_frame_err(frame_err),
    .o_overrun  (overrun),
    .o_baud_err (baud_err),
    .o_busy     (busy),
    .o_bit_cnt  (bit_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rx_valid && !prev_v) t_rise = cyc;
    prev_v = rx_valid;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] d, input int nbits);
    rxd = 1'b0;
    t_fall = cyc;
    wait_clk(bitclk);
    for (int i = 0; i < nbits; i++) begin
      rxd = d[i];
      wait_clk(bitclk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb, input bit chk_bc);
    send_bits(d, 8);
    rxd = stopb;
    wait_clk(bitclk / 4);
    if (chk_bc) chk("bit_cnt_in_stop", 32'(bit_cnt), 32'd9);
    wait_clk(bitclk - bitclk / 4);
    rxd = 1'b1;
    wait_clk(20);
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    wait_clk(1);
    rd_ack = 1'b0;
    wait_clk(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_data"},   32'(rx_data),   32'd0);
    chk({tag, "_rx_valid"},  32'(rx_valid),  32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_overrun"},   32'(overrun),   32'd0);
    chk({tag, "_baud_err"},  32'(baud_err),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_bit_cnt"},   32'(bit_cnt),   32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic       sb;
    bit         busy_seen;

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; sel = 1'b1; rx_en = 1'b1; baud = 20'd15; rxd = 1'b1; rd_ack = 1'b0;
    bitclk = 16 * 16;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    chk_all_zero("reset");
    wait_clk(10);

    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].d, tbl[i].stopb, 1'b1);
      if (i == 0) chk("latency_edge_to_valid", 32'(t_rise - t_fall), 32'd2435);
      chk($sformatf("tbl%0d_rx_data", i),   32'(rx_data),   32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_rx_valid", i),  32'(rx_valid),  32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_frame_err", i), 32'(frame_err), 32'(tbl[i].e_ferr));
      chk($sformatf("tbl%0d_overrun", i),   32'(overrun),   32'(tbl[i].e_ovr));
      chk($sformatf("tbl%0d_bit_cnt", i),   32'(bit_cnt),   32'd0);
      if (tbl[i].ack) begin
        pulse_ack();
        chk($sformatf("tbl%0d_valid_after_ack", i), 32'(rx_valid), 32'd0);
      end
    end

    pulse_ack();
    chk("ovr_ack_valid",   32'(rx_valid), 32'd0);
    chk("ovr_ack_overrun", 32'(overrun),  32'd0);
    pulse_ack();
    chk("idle_ack_valid",  32'(rx_valid), 32'd0);
    chk("idle_ack_data",   32'(rx_data),  32'h22);

    // start-bit glitch
    rxd = 1'b0;
    wait_clk(50);
    chk("glitch_busy_in_start", 32'(busy), 32'd1);
    rxd = 1'b1;
    wait_clk(150);
    chk("glitch_busy_after", 32'(busy),     32'd0);
    chk("glitch_rx_valid",   32'(rx_valid), 32'd0);

    // abort mid-frame by dropping rx_en
    send_bits(8'h5A, 4);
    chk("abort_bit_cnt_4", 32'(bit_cnt), 32'd4);
    chk("abort_busy_pre",  32'(busy),    32'd1);
    rx_en = 1'b0;
    wait_clk(1);
    chk("abort_bit_cnt_0", 32'(bit_cnt),  32'd0);
    chk("abort_busy_post", 32'(busy),     32'd0);
    chk("abort_rx_data",   32'(rx_data),  32'h22);
    rxd = 1'b1;
    wait_clk(20);
    rx_en = 1'b1;
    wait_clk(20);
    send_frame(8'h7E, 1'b1, 1'b0);
    chk("reen_rx_data",   32'(rx_data),   32'h7E);
    chk("reen_rx_valid",  32'(rx_valid),  32'd1);
    chk("reen_frame_err", 32'(frame_err), 32'd0);
    chk("reen_overrun",   32'(overrun),   32'd0);

    // baud below minimum
    baud = 20'd14;
    wait_clk(2);
    chk("baud_err_set", 32'(baud_err), 32'd1);
    busy_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rxd = 1'($urandom);
      wait_clk(1);
      if (busy) busy_seen = 1'b1;
    end
    chk("baud_err_no_busy", 32'(busy_seen), 32'd0);
    rxd = 1'b1;
    wait_clk(5);
    baud = 20'd15;
    wait_clk(2);
    chk("baud_err_clear", 32'(baud_err), 32'd0);

    // reset mid-frame with a word pending
    send_bits(8'h96, 3);
    rst = 1'b1;
    wait_clk(1);
    chk_all_zero("rst_mid");
    rst = 1'b0;
    rxd = 1'b1;
    wait_clk(20);

    // randomized frames against the word-level model
    m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      baud   = 20'(15 + $urandom_range(0, 2));
      bitclk = 16 * (int'(baud) + 1);
      d      = 8'($urandom);
      sb     = ($urandom_range(0, 3) != 0);
      send_frame(d, sb, 1'b0);
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = d;
      m_ferr  = ~sb;
      chk($sformatf("rnd%0d_rx_data", i),   32'(rx_data),   32'(m_data));
      chk($sformatf("rnd%0d_rx_valid", i),  32'(rx_valid),  32'(m_valid));
      chk($sformatf("rnd%0d_frame_err", i), 32'(frame_err), 32'(m_ferr));
      chk($sformatf("rnd%0d_overrun", i),   32'(overrun),   32'(m_ovr));
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        chk($sformatf("rnd%0d_ack_valid", i),   32'(rx_valid), 32'(m_valid));
        chk($sformatf("rnd%0d_ack_overrun", i), 32'(overrun),  32'(m_ovr));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
